mostra_sequencia: RTL and testbench

Presenter for the memory game: on request, reads the stored sequence from the ROM at addresses 0..limite and plays it on the LEDs. Each entry lights for ON_CYCLES, then the LEDs go dark for OFF_CYCLES.

---
 rtl/mostra_sequencia_pkg.sv | 23 ++
 rtl/mostra_sequencia_if.sv | 22 ++
 rtl/mostra_sequencia_contador_tempo.sv | 25 ++
 rtl/mostra_sequencia.sv | 113 +++++++++++
 tb/tb_mostra_sequencia.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mostra_sequencia_pkg.sv
// Shared types for the sequence presenter: FSM state encoding (mirrors db_estado)
// and the timer width helper.
package mostra_sequencia_pkg;

    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        CARREGA = 4'd1,
        ACENDE  = 4'd2,
        APAGA   = 4'd3,
        PROXIMO = 4'd4,
        FIM     = 4'd5
    } estado_t;

    // Bits needed to hold max(on, off) - 1, never less than one bit.
    function automatic int largura_timer(input int on_cycles, input int off_cycles);
        int maior;
        int w;
        maior = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        w     = $clog2(maior);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mostra_sequencia_if.sv
// Game-unit side of the presenter: start/pronto handshake plus the ROM read bus.
interface mostra_sequencia_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              iniciar;
    logic [ADDR_W-1:0] limite;
    logic              pronto;
    logic              mostrando;
    logic [ADDR_W-1:0] mem_endereco;
    logic [DATA_W-1:0] mem_dado;

    modport master (
        output iniciar, limite, mem_dado,
        input  pronto, mostrando, mem_endereco
    );

    modport slave (
        input  iniciar, limite, mem_dado,
        output pronto, mostrando, mem_endereco
    );
endinterface

// File: rtl/mostra_sequencia_contador_tempo.sv
// Loadable down-counter with a zero flag; shared by the lit and dark phases.
module contador_tempo #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         carrega,
    input  logic         decrementa,
    input  logic [W-1:0] valor,
    output logic         zero
);
    logic [W-1:0] conta;

    always_ff @(posedge clock) begin
        if (!reset) begin
            conta <= '0;
        end else if (carrega) begin
            conta <= valor;
        end else if (decrementa && conta != '0) begin
            conta <= conta - W'(1);
        end
    end

    assign zero = (conta == '0);
endmodule

// File: rtl/mostra_sequencia.sv
// Plays ROM entries 0..limite on the LEDs (lit ON_CYCLES, dark OFF_CYCLES each).
// Optional abort input enabled by defining MOSTRA_SEQUENCIA_ABORTA_EN.
module mostra_sequencia
    import mostra_sequencia_pkg::*;
#(
    parameter int ON_CYCLES  = 1000,
    parameter int OFF_CYCLES = 500,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4
) (
    input  logic              clock,
    input  logic              reset,
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
    input  logic              abortar,
`endif
    mostra_sequencia_if.slave jogo,
    output logic [DATA_W-1:0] leds,
    output logic [3:0]        db_estado
);
    localparam int TW = largura_timer(ON_CYCLES, OFF_CYCLES);
    localparam logic [TW-1:0] CARGA_ON  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] CARGA_OFF = TW'(OFF_CYCLES - 1);

    estado_t           estado;
    estado_t           proximo;
    logic [ADDR_W-1:0] endereco;
    logic [ADDR_W-1:0] limite_reg;
    logic [DATA_W-1:0] entrada;

    logic              t_carrega;
    logic              t_decrementa;
    logic [TW-1:0]     t_valor;
    logic              t_zero;

    contador_tempo #(.W(TW)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .carrega    (t_carrega),
        .decrementa (t_decrementa),
        .valor      (t_valor),
        .zero       (t_zero)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:  if (jogo.iniciar) proximo = CARREGA;
            CARREGA: proximo = ACENDE;
            ACENDE:  if (t_zero) proximo = APAGA;
            APAGA:   if (t_zero) proximo = (endereco == limite_reg) ? FIM : PROXIMO;
            PROXIMO: proximo = CARREGA;
            FIM:     proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
        if (abortar && estado != OCIOSO) begin
            proximo = OCIOSO;
        end
`endif
    end

    always_comb begin
        leds           = '0;
        jogo.mostrando = (estado != OCIOSO);
        jogo.pronto    = (estado == FIM);
        db_estado      = estado;
        t_carrega      = 1'b0;
        t_decrementa   = 1'b0;
        t_valor        = CARGA_ON;
        case (estado)
            CARREGA: t_carrega = 1'b1;
            ACENDE: begin
                leds         = entrada;
                t_decrementa = 1'b1;
                t_carrega    = t_zero;
                t_valor      = CARGA_OFF;
            end
            APAGA:   t_decrementa = 1'b1;
            default: ;
        endcase
    end

    // Address clears on every entry into OCIOSO (normal finish or abort).
    always_ff @(posedge clock) begin
        if (!reset) begin
            endereco   <= '0;
            limite_reg <= '0;
            entrada    <= '0;
        end else begin
            if (estado == OCIOSO && jogo.iniciar) begin
                limite_reg <= jogo.limite;
            end
            if (proximo == OCIOSO) begin
                endereco <= '0;
            end else if (estado == PROXIMO) begin
                endereco <= endereco + ADDR_W'(1);
            end
            if (estado == CARREGA) begin
                entrada <= jogo.mem_dado;
            end
        end
    end

    assign jogo.mem_endereco = endereco;
endmodule

// File: tb/tb_mostra_sequencia.sv
// Randomized bench for mostra_sequencia; expected outputs come from the
// per-entry cycle schedule computed arithmetically from the cycle index.
module tb_mostra_sequencia;
    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int P   = ON + OFF + 2;

    logic       clock;
    logic       reset;
    logic [3:0] leds;
    logic [3:0] db_estado;
    logic [3:0] rom [16];
    int         n_tests;
    int         n_fail;

    mostra_sequencia_if #(.ADDR_W(4), .DATA_W(4)) ifc ();

`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
    logic abortar;
`endif

    mostra_sequencia #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .ADDR_W     (4),
        .DATA_W     (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
        .abortar   (abortar),
`endif
        .jogo      (ifc),
        .leds      (leds),
        .db_estado (db_estado)
    );

    assign ifc.mem_dado = rom[ifc.mem_endereco];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".estado"},    db_estado,        0);
        check({tag, ".leds"},      leds,             0);
        check({tag, ".endereco"},  ifc.mem_endereco, 0);
        check({tag, ".mostrando"}, ifc.mostrando,    0);
        check({tag, ".pronto"},    ifc.pronto,       0);
    endtask

    // Cycle c (1-based, counted from the accepting edge) of a run ending at entry lim.
    task automatic expect_cycle(input int c, input int lim);
        int         i;
        int         off;
        logic [3:0] st;
        logic [3:0] ld;
        i   = (c - 1) / P;
        off = (c - 1) % P;
        ld  = 4'd0;
        if (off == 0) begin
            st = 4'd1;
        end else if (off <= ON) begin
            st = 4'd2;
            ld = rom[i];
        end else if (off <= ON + OFF) begin
            st = 4'd3;
        end else begin
            st = (i == lim) ? 4'd5 : 4'd4;
        end
        check("estado",    db_estado,        st);
        check("leds",      leds,             ld);
        check("endereco",  ifc.mem_endereco, i);
        check("mostrando", ifc.mostrando,    1);
        check("pronto",    ifc.pronto,       (st == 4'd5));
    endtask

    task automatic follow(input int lim, input int from_c, input int to_c, input bit keep);
        for (int c = from_c; c <= to_c; c++) begin
            @(posedge clock);
            #1;
            expect_cycle(c, lim);
            if (!keep) begin
                ifc.iniciar = 1'b0;
                ifc.limite  = 4'($urandom);
            end
        end
    endtask

    task automatic tick_idle(input string tag);
        @(posedge clock);
        #1;
        expect_idle(tag);
    endtask

    task automatic run_normal(input int lim);
        ifc.iniciar = 1'b1;
        ifc.limite  = 4'(lim);
        follow(lim, 1, (lim + 1) * P, 1'b0);
        tick_idle("fim_ocioso");
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        ifc.iniciar = 1'b0;
        ifc.limite  = '0;
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
        abortar = 1'b0;
`endif
        for (int k = 0; k < 16; k++) rom[k] = 4'(1 << (k % 4));

        repeat (2) @(posedge clock);
        #1;
        expect_idle("reset");
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ifc.limite = 4'($urandom);
            tick_idle("ocioso");
        end

        run_normal(0);
        run_normal(3);

        // iniciar held: no restart until OCIOSO, then a new run on the next edge
        ifc.iniciar = 1'b1;
        ifc.limite  = 4'd1;
        follow(1, 1, 2 * P, 1'b1);
        tick_idle("held_ocioso");
        follow(1, 1, 2 * P, 1'b0);
        tick_idle("held_fim");

        // reset in cycle 11 of a limite=3 run
        ifc.iniciar = 1'b1;
        ifc.limite  = 4'd3;
        follow(3, 1, 11, 1'b0);
        reset = 1'b0;
        tick_idle("mid_reset");
        reset = 1'b1;
        repeat (3) tick_idle("after_reset");

        run_normal(15);
        tick_idle("wrap_check");

`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
        ifc.iniciar = 1'b1;
        ifc.limite  = 4'd3;
        follow(3, 1, 2 * P + 2, 1'b0);
        abortar = 1'b1;
        tick_idle("abort");
        abortar = 1'b0;
        tick_idle("abort_idle");
        ifc.iniciar = 1'b1;
        ifc.limite  = 4'd3;
        abortar     = 1'b1;
        @(posedge clock);
        #1;
        abortar     = 1'b0;
        ifc.iniciar = 1'b0;
        expect_cycle(1, 3);
        follow(3, 2, 4 * P, 1'b0);
        tick_idle("abort_rerun");
`endif

        for (int r = 0; r < 5; r++) begin
            int lim;
            for (int k = 0; k < 16; k++) rom[k] = 4'($urandom_range(0, 15));
            lim = $urandom_range(0, 15);
            repeat ($urandom_range(0, 3)) tick_idle("gap");
            run_normal(lim);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
